regfile_dump: RTL

- Debug readout engine: on request, walks the CPU register file through one read port, serialises every register onto a byte-wide valid/ready stream toward the debug UART transmitter, and finishes with an XOR checksum byte.
- Sits beside the register file; shares read port 2 with the core through an external mux selected by busy.

---
 rtl/regfile_dump.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// Debug readout engine: walks the register file through one read port and streams
// a header, every register word (4 bytes each) and a closing XOR checksum byte.
module regfile_dump #(
    parameter int          NUM_REGS  = 32,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    logic [2:0]  state_reg, state_next;
    logic [4:0]  idx_reg, idx_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] shift_reg, shift_next;
    logic [7:0]  csum_reg, csum_next;

    logic [7:0]  send_byte;
    logic        handshake;

    assign send_byte = MSB_FIRST ? shift_reg[31:24] : shift_reg[7:0];

    // Every output is decoded from registered state only, so tx_ready never reaches tx_valid.
    assign tx_valid  = (state_reg == HDR) || (state_reg == SEND) || (state_reg == CSUM);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);
    assign rd_addr   = busy ? idx_reg : 5'd0;
    assign handshake = tx_valid && tx_ready;

    always_comb begin
        tx_data = 8'h00;
        case (state_reg)
            HDR:     tx_data = HEADER;
            SEND:    tx_data = send_byte;
            CSUM:    tx_data = csum_reg;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        csum_next     = csum_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                    idx_next   = 5'd0;
                    csum_next  = 8'h00;
                end
            end
            HDR: begin
                if (handshake) state_next = LOAD;
            end
            LOAD: begin
                // The register is snapshotted here; earlier writes are seen, later ones are not.
                shift_next    = rd_data;
                byte_cnt_next = 2'd0;
                state_next    = SEND;
            end
            SEND: begin
                if (handshake) begin
                    csum_next     = csum_reg ^ send_byte;
                    shift_next    = MSB_FIRST ? {shift_reg[23:0], 8'h00} : {8'h00, shift_reg[31:8]};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        if (idx_reg == LAST_IDX) begin
                            state_next = CSUM;
                        end else begin
                            idx_next   = idx_reg + 5'd1;
                            state_next = LOAD;
                        end
                    end
                end
            end
            CSUM: begin
                if (handshake) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= 5'd0;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
            csum_reg     <= 8'h00;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            csum_reg     <= csum_next;
        end
    end

endmodule
